otter_pipe_ctrl: RTL and testbench

- Pipeline sequencer for the 5-stage Otter core. It sits downstream of the hazard/forwarding unit and consumes its `stall` request.
- It also consumes branch redirect, instruction/data memory readiness and halt requests.
- It drives per-stage register write enables, per-stage valid (bubble) bits and the PC enable/select.
- It owns the drain/halt state machine and the stall, flush and retire performance counters.

---
 rtl/otter_pkg.sv | 19 +
 rtl/otter_perf_cnt.sv | 19 +
 rtl/otter_pipe_ctrl.sv | 149 ++++++++++++++
 tb/tb_otter_pipe_ctrl.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/otter_pkg.sv
// Shared types and constants for the Otter pipeline sequencer.
package otter_pkg;

    localparam int unsigned DEF_CNT_W = 32;

    typedef enum logic [2:0] {
        ST_RUN       = 3'd0,
        ST_IMEM_WAIT = 3'd1,
        ST_DMEM_WAIT = 3'd2,
        ST_DRAIN     = 3'd3,
        ST_HALTED    = 3'd4
    } pipe_state_e;

    typedef struct packed {
        logic we;
        logic valid;
    } stage_ctrl_t;

endpackage

// File: rtl/otter_perf_cnt.sv
// Single-increment performance counter, wraps modulo 2^W.
module otter_perf_cnt #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (inc) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/otter_pipe_ctrl.sv
// Otter 5-stage pipeline sequencer: stage enables, bubble bits, drain/halt FSM
// and stall/flush/retire counters.
module otter_pipe_ctrl
    import otter_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic             imem_ready,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    input  logic             halt_req,
    output logic             pc_we,
    output logic             pc_sel_redirect,
    output logic             if_id_we,
    output logic             id_ex_we,
    output logic             ex_mem_we,
    output logic             mem_wb_we,
    output logic             if_id_valid,
    output logic             id_ex_valid,
    output logic             ex_mem_valid,
    output logic             mem_wb_valid,
    output logic             halted,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] retire_cnt
);

    // Stage index: 0=IF/ID, 1=ID/EX, 2=EX/MEM, 3=MEM/WB
    pipe_state_e state_q, state_nxt;
    logic [3:0]  vld_q, vld_nxt;
    logic [3:0]  we_c;
    logic        pc_we_c, sel_c, stall_inc, flush_inc;
    logic        dfrz, redir, lu, ifw;
    stage_ctrl_t [3:0] stg;

    assign dfrz  = vld_q[2] & dmem_req & ~dmem_ready;
    assign redir = vld_q[1] & branch_taken;
    assign lu    = stall & vld_q[0];
    assign ifw   = ~imem_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RUN;
            vld_q   <= 4'b0000;
        end else begin
            state_q <= state_nxt;
            vld_q   <= vld_nxt;
        end
    end

    // Highest-priority event wins; DRAIN ignores fetch-side stalls since IF/ID is discarded.
    always_comb begin
        state_nxt = state_q;
        vld_nxt   = vld_q;
        we_c      = 4'b0000;
        pc_we_c   = 1'b0;
        sel_c     = 1'b0;
        stall_inc = 1'b0;
        flush_inc = 1'b0;
        if (state_q == ST_HALTED) begin
            state_nxt = ST_HALTED;
        end else if (dfrz) begin
            we_c       = 4'b1000;
            vld_nxt[3] = 1'b0;
            stall_inc  = 1'b1;
            if (state_q != ST_DRAIN) begin
                state_nxt = ST_DMEM_WAIT;
            end
        end else if (redir) begin
            pc_we_c   = 1'b1;
            sel_c     = 1'b1;
            we_c      = 4'b1111;
            vld_nxt   = {vld_q[2], vld_q[1], 1'b0, 1'b0};
            flush_inc = 1'b1;
            state_nxt = ST_RUN;
        end else if (state_q == ST_DRAIN) begin
            we_c    = 4'b1111;
            vld_nxt = {vld_q[2:0], 1'b0};
            if (vld_q[3:1] == 3'b000) begin
                state_nxt = ST_HALTED;
            end
        end else if (lu) begin
            we_c      = 4'b1110;
            vld_nxt   = {vld_q[2], vld_q[1], 1'b0, vld_q[0]};
            stall_inc = 1'b1;
            state_nxt = ST_RUN;
        end else begin
            we_c      = 4'b1111;
            pc_we_c   = imem_ready;
            vld_nxt   = {vld_q[2:0], imem_ready};
            stall_inc = ifw;
            if (halt_req & vld_q[0]) begin
                state_nxt = ST_DRAIN;
            end else if (ifw) begin
                state_nxt = ST_IMEM_WAIT;
            end else begin
                state_nxt = ST_RUN;
            end
        end
    end

    // Enables are forced low while reset is held.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            stg[i].we    = reset & we_c[i];
            stg[i].valid = vld_q[i];
        end
    end

    assign pc_we           = reset & pc_we_c;
    assign pc_sel_redirect = reset & sel_c;
    assign if_id_we        = stg[0].we;
    assign id_ex_we        = stg[1].we;
    assign ex_mem_we       = stg[2].we;
    assign mem_wb_we       = stg[3].we;
    assign if_id_valid     = stg[0].valid;
    assign id_ex_valid     = stg[1].valid;
    assign ex_mem_valid    = stg[2].valid;
    assign mem_wb_valid    = stg[3].valid;
    assign halted          = (state_q == ST_HALTED);
    assign state           = state_q;

    otter_perf_cnt #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    otter_perf_cnt #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush_inc),
        .count (flush_cnt)
    );

    otter_perf_cnt #(.W(CNT_W)) u_retire_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (vld_q[3]),
        .count (retire_cnt)
    );

endmodule

// File: tb/tb_otter_pipe_ctrl.sv
// Self-checking bench for otter_pipe_ctrl: directed scenarios plus randomized run
// against a slot-occupancy reference model.
module tb_otter_pipe_ctrl;

    localparam int unsigned CW = 32;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic stall = 1'b0, branch_taken = 1'b0, imem_ready = 1'b0;
    logic dmem_req = 1'b0, dmem_ready = 1'b0, halt_req = 1'b0;
    logic pc_we, pc_sel_redirect, if_id_we, id_ex_we, ex_mem_we, mem_wb_we;
    logic if_id_valid, id_ex_valid, ex_mem_valid, mem_wb_valid, halted;
    logic [2:0] state;
    logic [CW-1:0] stall_cnt, flush_cnt, retire_cnt;
    logic [3:0] dut_v, dut_we;
    logic [5:0] dut_comb;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    otter_pipe_ctrl #(.CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
        .imem_ready(imem_ready), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .halt_req(halt_req), .pc_we(pc_we), .pc_sel_redirect(pc_sel_redirect),
        .if_id_we(if_id_we), .id_ex_we(id_ex_we), .ex_mem_we(ex_mem_we),
        .mem_wb_we(mem_wb_we), .if_id_valid(if_id_valid), .id_ex_valid(id_ex_valid),
        .ex_mem_valid(ex_mem_valid), .mem_wb_valid(mem_wb_valid), .halted(halted),
        .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .retire_cnt(retire_cnt)
    );

    assign dut_v    = {mem_wb_valid, ex_mem_valid, id_ex_valid, if_id_valid};
    assign dut_we   = {mem_wb_we, ex_mem_we, id_ex_we, if_id_we};
    assign dut_comb = {pc_we, pc_sel_redirect, dut_we};

    // Reference model: slot occupancy per stage, state code, counters
    typedef enum int {A_HALT, A_FRZ, A_RED, A_DRN, A_LU, A_IFW, A_NRM} act_t;
    bit [3:0] m_v;
    int m_st;
    logic [CW-1:0] m_stall, m_flush, m_retire;

    task automatic model_reset();
        m_v = 4'b0000; m_st = 0; m_stall = '0; m_flush = '0; m_retire = '0;
    endtask

    function automatic act_t m_act();
        if (m_st == 4) return A_HALT;
        if (m_v[2] && dmem_req && !dmem_ready) return A_FRZ;
        if (m_v[1] && branch_taken) return A_RED;
        if (m_st == 3) return A_DRN;
        if (stall && m_v[0]) return A_LU;
        if (!imem_ready) return A_IFW;
        return A_NRM;
    endfunction

    function automatic logic [3:0] m_adv(act_t a);
        case (a)
            A_HALT:  return 4'b0000;
            A_FRZ:   return 4'b1000;
            A_LU:    return 4'b1110;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [5:0] m_comb(act_t a);
        logic pc, sel;
        pc  = (a == A_RED) || (a == A_NRM);
        sel = (a == A_RED);
        return {pc, sel, m_adv(a)};
    endfunction

    task automatic model_edge();
        act_t a;
        bit [3:0] adv, kill, nv;
        bit src;
        a    = m_act();
        adv  = m_adv(a);
        kill = (a == A_FRZ) ? 4'b1000 : (a == A_RED) ? 4'b0011 :
               (a == A_LU)  ? 4'b0010 : 4'b0000;
        for (int k = 0; k < 4; k++) begin
            src   = (k == 0) ? (a == A_NRM) : m_v[k-1];
            nv[k] = (adv[k] ? src : m_v[k]) & ~kill[k];
        end
        if (m_v[3]) m_retire = m_retire + 1;
        if (a inside {A_FRZ, A_LU, A_IFW}) m_stall = m_stall + 1;
        if (a == A_RED) m_flush = m_flush + 1;
        case (a)
            A_HALT: m_st = 4;
            A_FRZ:  m_st = (m_st == 3) ? 3 : 2;
            A_RED:  m_st = 0;
            A_DRN:  m_st = (m_v[3:1] == 3'b000) ? 4 : 3;
            A_LU:   m_st = 0;
            default: m_st = (halt_req && m_v[0]) ? 3 : (a == A_IFW) ? 1 : 0;
        endcase
        m_v = nv;
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) model_edge();
        @(negedge clk);
    endtask

    task automatic idle();
        stall = 1'b0; branch_taken = 1'b0; imem_ready = 1'b1;
        dmem_req = 1'b0; dmem_ready = 1'b0; halt_req = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic fill4();
        idle();
        repeat (4) tick();
    endtask

    task automatic test_reset();
        idle(); stall = 1'b1; branch_taken = 1'b1;
        reset = 1'b0; model_reset();
        #1;
        total++;
        if (dut_comb !== 6'b000000) begin
            bad++; $display("FAIL reset_enables got=%b want=%b", dut_comb, 6'b000000);
        end
        total++;
        if (state !== 3'd0 || dut_v !== 4'b0000 || halted !== 1'b0) begin
            bad++; $display("FAIL reset_regs state=%0d valids=%b halted=%b want 0/0000/0", state, dut_v, halted);
        end
        total++;
        if (stall_cnt !== '0 || flush_cnt !== '0 || retire_cnt !== '0) begin
            bad++; $display("FAIL reset_cnt got=%0d/%0d/%0d want 0/0/0", stall_cnt, flush_cnt, retire_cnt);
        end
        @(posedge clk); @(negedge clk);
        total++;
        if (dut_v !== 4'b0000) begin
            bad++; $display("FAIL reset_hold valids=%b want=0000", dut_v);
        end
        reset = 1'b1;
        idle();
    endtask

    task automatic test_fill();
        logic [3:0] exp_v [5] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1111};
        idle();
        for (int i = 0; i < 5; i++) begin
            #1;
            total++;
            if (dut_comb !== 6'b101111) begin
                bad++; $display("FAIL fill_en[%0d] got=%b want=%b", i, dut_comb, 6'b101111);
            end
            tick();
            total++;
            if (dut_v !== exp_v[i]) begin
                bad++; $display("FAIL fill_valid[%0d] got=%b want=%b", i, dut_v, exp_v[i]);
            end
        end
        total++;
        if (retire_cnt !== 32'd1) begin
            bad++; $display("FAIL fill_retire got=%0d want=1", retire_cnt);
        end
    endtask

    task automatic test_load_use();
        stall = 1'b1;
        #1;
        total++;
        if (dut_comb !== 6'b001110) begin
            bad++; $display("FAIL lu_en got=%b want=%b", dut_comb, 6'b001110);
        end
        tick();
        stall = 1'b0;
        total++;
        if (dut_v !== 4'b1101) begin
            bad++; $display("FAIL lu_valid got=%b want=1101", dut_v);
        end
        total++;
        if (stall_cnt !== 32'd1) begin
            bad++; $display("FAIL lu_stall_cnt got=%0d want=1", stall_cnt);
        end
    endtask

    task automatic test_redirect_priority();
        tick();
        total++;
        if (dut_v !== 4'b1011) begin
            bad++; $display("FAIL red_setup got=%b want=1011", dut_v);
        end
        branch_taken = 1'b1; stall = 1'b1; imem_ready = 1'b0;
        #1;
        total++;
        if (dut_comb !== 6'b111111) begin
            bad++; $display("FAIL red_en got=%b want=%b", dut_comb, 6'b111111);
        end
        tick();
        total++;
        if (dut_v !== 4'b0100 || state !== 3'd0) begin
            bad++; $display("FAIL red_valid got=%b st=%0d want=0100 st=0", dut_v, state);
        end
        total++;
        if (flush_cnt !== 32'd1 || stall_cnt !== 32'd1) begin
            bad++; $display("FAIL red_cnt flush=%0d stall=%0d want 1/1", flush_cnt, stall_cnt);
        end
        idle();
    endtask

    task automatic test_dmem_freeze();
        do_reset();
        fill4();
        dmem_req = 1'b1; dmem_ready = 1'b0; branch_taken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (dut_comb !== 6'b001000) begin
                bad++; $display("FAIL frz_en[%0d] got=%b want=%b", i, dut_comb, 6'b001000);
            end
            tick();
            total++;
            if (state !== 3'd2 || dut_v !== 4'b0111) begin
                bad++; $display("FAIL frz_regs[%0d] st=%0d v=%b want st=2 v=0111", i, state, dut_v);
            end
        end
        dmem_ready = 1'b1;
        #1;
        total++;
        if (dut_comb !== 6'b111111) begin
            bad++; $display("FAIL frz_release_en got=%b want=%b", dut_comb, 6'b111111);
        end
        tick();
        total++;
        if (state !== 3'd0 || dut_v !== 4'b1100) begin
            bad++; $display("FAIL frz_release st=%0d v=%b want st=0 v=1100", state, dut_v);
        end
        total++;
        if (flush_cnt !== 32'd1 || stall_cnt !== 32'd3) begin
            bad++; $display("FAIL frz_cnt flush=%0d stall=%0d want 1/3", flush_cnt, stall_cnt);
        end
        idle();
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        fill4();
        dmem_req = 1'b1; dmem_ready = 1'b0;
        tick();
        reset = 1'b0; model_reset();
        #1;
        total++;
        if (state !== 3'd0 || dut_v !== 4'b0000 || stall_cnt !== '0 || dut_comb !== 6'b0) begin
            bad++; $display("FAIL midrst st=%0d v=%b stall=%0d en=%b want 0/0000/0/0", state, dut_v, stall_cnt, dut_comb);
        end
        @(posedge clk); @(negedge clk);
        reset = 1'b1;
        idle();
        tick();
        total++;
        if (state !== 3'd0 || dut_v !== 4'b0001) begin
            bad++; $display("FAIL midrst_release st=%0d v=%b want st=0 v=0001", state, dut_v);
        end
    endtask

    task automatic test_halt();
        int exp_st [5] = '{3, 3, 3, 3, 4};
        logic [3:0] exp_v [5] = '{4'b1110, 4'b1100, 4'b1000, 4'b0000, 4'b0000};
        do_reset();
        fill4();
        halt_req = 1'b1;
        #1;
        total++;
        if (dut_comb !== 6'b101111) begin
            bad++; $display("FAIL halt_req_en got=%b want=%b", dut_comb, 6'b101111);
        end
        tick();
        halt_req = 1'b0;
        total++;
        if (state !== 3'd3 || dut_v !== 4'b1111) begin
            bad++; $display("FAIL halt_enter st=%0d v=%b want st=3 v=1111", state, dut_v);
        end
        for (int i = 0; i < 5; i++) begin
            #1;
            total++;
            if (dut_comb !== 6'b001111) begin
                bad++; $display("FAIL drain_en[%0d] got=%b want=%b", i, dut_comb, 6'b001111);
            end
            tick();
            total++;
            if (state !== 3'(exp_st[i]) || dut_v !== exp_v[i]) begin
                bad++; $display("FAIL drain[%0d] st=%0d v=%b want st=%0d v=%b", i, state, dut_v, exp_st[i], exp_v[i]);
            end
        end
        #1;
        total++;
        if (halted !== 1'b1 || dut_comb !== 6'b000000) begin
            bad++; $display("FAIL halted halted=%b en=%b want 1/000000", halted, dut_comb);
        end
        tick(); tick();
        total++;
        if (state !== 3'd4) begin
            bad++; $display("FAIL halted_sticky st=%0d want=4", state);
        end
        reset = 1'b0; model_reset();
        #1;
        total++;
        if (state !== 3'd0 || halted !== 1'b0 || retire_cnt !== '0 || stall_cnt !== '0 || flush_cnt !== '0) begin
            bad++; $display("FAIL halt_reset st=%0d halted=%b cnt=%0d/%0d/%0d want 0/0/0/0/0", state, halted, stall_cnt, flush_cnt, retire_cnt);
        end
        @(posedge clk); @(negedge clk);
        reset = 1'b1;
        idle();
    endtask

    task automatic test_random();
        logic [5:0] exp_c;
        do_reset();
        for (int n = 0; n < 800; n++) begin
            if (m_st == 4 && $urandom_range(3) == 0) begin
                reset = 1'b0; model_reset();
                #1;
                total++;
                if (state !== 3'd0 || dut_v !== 4'b0000 || retire_cnt !== '0) begin
                    bad++; $display("FAIL rand_reset[%0d] st=%0d v=%b ret=%0d want 0/0000/0", n, state, dut_v, retire_cnt);
                end
                @(posedge clk); @(negedge clk);
                reset = 1'b1;
            end
            stall        = ($urandom_range(9) < 3);
            branch_taken = ($urandom_range(3) == 0);
            imem_ready   = ($urandom_range(9) < 8);
            dmem_req     = $urandom_range(1) == 1;
            dmem_ready   = ($urandom_range(9) < 6);
            halt_req     = imem_ready && ($urandom_range(7) == 0);
            #1;
            exp_c = m_comb(m_act());
            total++;
            if (dut_comb !== exp_c) begin
                bad++; $display("FAIL rand_en[%0d] got=%b want=%b", n, dut_comb, exp_c);
            end
            tick();
            total++;
            if (state !== 3'(m_st) || dut_v !== m_v || halted !== (m_st == 4)) begin
                bad++; $display("FAIL rand_regs[%0d] st=%0d v=%b h=%b want st=%0d v=%b", n, state, dut_v, halted, m_st, m_v);
            end
            total++;
            if (stall_cnt !== m_stall || flush_cnt !== m_flush || retire_cnt !== m_retire) begin
                bad++; $display("FAIL rand_cnt[%0d] got=%0d/%0d/%0d want=%0d/%0d/%0d", n,
                                stall_cnt, flush_cnt, retire_cnt, m_stall, m_flush, m_retire);
            end
        end
        idle();
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        test_reset();
        test_fill();
        test_load_use();
        test_redirect_priority();
        test_dmem_freeze();
        test_reset_mid_stall();
        test_halt();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
